// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU share arbiter: ALUOP encodings, the
// arbiter FSM state encoding and an opcode legality helper.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_AND = 4'd2;
    localparam logic [3:0] ALUOP_OR  = 4'd3;
    localparam logic [3:0] ALUOP_XOR = 4'd4;
    localparam logic [3:0] ALUOP_NOR = 4'd5;
    localparam logic [3:0] ALUOP_SLL = 4'd6;
    localparam logic [3:0] ALUOP_SRL = 4'd7;
    localparam logic [3:0] ALUOP_SLT = 4'd8;
    localparam logic [3:0] ALUOP_SGT = 4'd9;
    localparam logic [3:0] ALUOP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALUOP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-input grant logic. Default build: round-robin, preferring the input
// that did not win last time (last_grant resets to 1 so input 0 wins first).
// With ALU_ARB_FIXED_PRIO_EN defined: input 0 always wins when valid and no
// history is kept.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   req_valid_i - request valid per input
//   update_i    - a grant was accepted this cycle; record it as last winner
//   grant_o     - index of the winning input (meaningful when any valid)
// ----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid_i,
    input  logic       update_i,
    output logic       grant_o
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    // History-free: these inputs are intentionally left without a consumer.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, update_i, req_valid_i[1]};
    assign grant_o       = ~req_valid_i[0];

`else

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_o = ~last_grant_q;
        case (req_valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            default: grant_o = ~last_grant_q;
        endcase
        last_grant_d = update_i ? grant_o : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external ALU between two requesters. One operation is in flight
// at a time: IDLE (arbitrate/accept) -> EXEC (ALU driven from registers) ->
// RESP (registered result held until the owner accepts it).
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0)
// instead of round-robin; timing and handshakes are unchanged.
//
// Ports:
//   clk, rst_n            - clock / asynchronous active-low reset
//   req_valid/req_ready   - per-requester request handshake
//   req_a, req_b, req_op  - packed operands (bit_width each) and 4-bit opcodes
//   rsp_valid/rsp_ready   - one-hot response handshake to the owner
//   rsp_res/zf/cf/err     - registered result, flags, illegal-opcode flag
//   alu_a, alu_b, alu_op  - registered drive to the external ALU
//   alu_res, alu_zf, alu_cf - external ALU outputs
// ----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int bit_width = 32,
    parameter int NUM_REQ   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*bit_width-1:0] req_a,
    input  logic [NUM_REQ*bit_width-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]         req_op,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [bit_width-1:0]         rsp_res,
    output logic                         rsp_zf,
    output logic                         rsp_cf,
    output logic                         rsp_err,
    output logic [bit_width-1:0]         alu_a,
    output logic [bit_width-1:0]         alu_b,
    output logic [3:0]                   alu_op,
    input  logic [bit_width-1:0]         alu_res,
    input  logic                         alu_zf,
    input  logic                         alu_cf
);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 illegal_q, illegal_d;
    logic [bit_width-1:0] alu_a_q, alu_a_d;
    logic [bit_width-1:0] alu_b_q, alu_b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [bit_width-1:0] rsp_res_q, rsp_res_d;
    logic                 rsp_zf_q, rsp_zf_d;
    logic                 rsp_cf_q, rsp_cf_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 grant;
    logic                 accept;
    logic [bit_width-1:0] sel_a, sel_b;
    logic [3:0]           sel_op;

    // Arbiter history only advances on an actual accept.
    assign accept = (state_q == IDLE) && req_valid[grant];

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .update_i    (accept),
        .grant_o     (grant)
    );

    assign sel_a  = grant ? req_a[2*bit_width-1 -: bit_width] : req_a[bit_width-1:0];
    assign sel_b  = grant ? req_b[2*bit_width-1 -: bit_width] : req_b[bit_width-1:0];
    assign sel_op = grant ? req_op[7:4] : req_op[3:0];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        illegal_d = illegal_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        rsp_res_d = rsp_res_q;
        rsp_zf_d  = rsp_zf_q;
        rsp_cf_d  = rsp_cf_q;
        rsp_err_d = rsp_err_q;
        req_ready = '0;
        rsp_valid = '0;

        case (state_q)
            IDLE: begin
                if (req_valid[grant]) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    owner_d   = grant;
                    alu_a_d   = sel_a;
                    alu_b_d   = sel_b;
                    illegal_d = !op_is_legal(sel_op);
                    // An illegal opcode never reaches the ALU; it keeps the last legal one.
                    if (op_is_legal(sel_op)) alu_op_d = sel_op;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (illegal_q) begin
                    rsp_res_d = '0;
                    rsp_zf_d  = 1'b1;
                    rsp_cf_d  = 1'b0;
                    rsp_err_d = 1'b1;
                end else begin
                    rsp_res_d = alu_res;
                    rsp_zf_d  = alu_zf;
                    rsp_cf_d  = alu_cf;
                    rsp_err_d = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            illegal_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= 4'd0;
            rsp_res_q <= '0;
            rsp_zf_q  <= 1'b1;
            rsp_cf_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            illegal_q <= illegal_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            rsp_res_q <= rsp_res_d;
            rsp_zf_q  <= rsp_zf_d;
            rsp_cf_q  <= rsp_cf_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign rsp_res = rsp_res_q;
    assign rsp_zf  = rsp_zf_q;
    assign rsp_cf  = rsp_cf_q;
    assign rsp_err = rsp_err_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one pipeline ALU between two requesters, e.g. the EX-stage main path (port 0) and a multi-cycle helper unit (port 1).
- Arbitrates between the requesters and sequences each accepted operation through the external ALU, driving A, B and ALUOP.
- Captures the result, ZF and CF into a register and returns them to the winning requester over a valid/ready response channel.
- Exactly one operation is in flight at a time.

Parameters:
- bit_width, 32, operand/result width; must match the ALU instance.
- NUM_REQ, 2, number of requesters; fixed at 2 for this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accept.
- req_a  in  2*bit_width  operand A, requester i at bits [i*bit_width +: bit_width].
- req_b  in  2*bit_width  operand B, same packing as req_a.
- req_op  in  8  4-bit ALUOP per requester, requester i at [i*4 +: 4].
- rsp_valid  out  2  one-hot response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_res  out  bit_width  registered ALU result.
- rsp_zf  out  1  registered zero flag.
- rsp_cf  out  1  registered carry flag.
- rsp_err  out  1  illegal-opcode flag.
- alu_a  out  bit_width  to ALU A.
- alu_b  out  bit_width  to ALU B.
- alu_op  out  4  to ALU ALUOP.
- alu_res  in  bit_width  from ALU res.
- alu_zf  in  1  from ALU ZF.
- alu_cf  in  1  from ALU CF.

Behaviour:
- Clock/reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins first), rsp_valid=0, rsp_res=0, rsp_zf=1, rsp_cf=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = round-robin over req_valid, preferring the requester that is not last_grant.
  - req_ready[grant]=1 only in IDLE and only if req_valid[grant]; the other bit is 0.
  - req_ready does not depend on rsp_ready.
  - On handshake, latch a, b, op and owner into operand registers, update last_grant, go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_op driven from the operand registers, which are registered outputs, so there is no combinational path from req_* to alu_*.
  - Valid opcodes 0..9: capture alu_res/alu_zf/alu_cf at the end of the cycle with rsp_err=0.
  - Opcodes 10..15: capture res=0, zf=1, cf=0, err=1, and hold alu_op at its previous value.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; response fields stay stable until rsp_ready[owner].
  - On handshake return to IDLE; there is no back-to-back bypass.
  - rsp_ready on the non-owner bit is ignored.
- Latency: request handshake at cycle T gives rsp_valid high at T+2. Maximum throughput is one op per 3 cycles.
- Holding: alu_* hold their last value outside EXEC. The CF feedback of shift ops with B=0 depends on the ALU's held CF, and this block passes it through unmodified.
- Both valid with last_grant=0: requester 1 wins. A continuously requesting loser wins the next arbitration (no starvation).
- A request that is deasserted before handshake is dropped silently.
- Reset mid-EXEC or mid-RESP: the operation is discarded and no response is issued.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid, and last_grant is not used.
- Undefined: round-robin as above.
- Latency and handshakes are identical in both modes.

Decomposition:
- Package alu_pkg holds:
  - ALUOP constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SLT=8, SGT=9, plus ALUOP_MAX=9.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module, rr_arbiter2: 2-input round-robin/fixed-priority grant logic with last_grant register.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Single op: req_valid=01, a=5, b=7, op=0 -> rsp_valid=01 two cycles after handshake, res=12, zf=0, cf=0, err=0.
- Contention: both valid every cycle, r0 SUB 3-3, r1 SLT -1,2 -> grants alternate 0,1,0,1. r0 gets res=0, zf=1; r1 gets res=1. No requester is granted twice in a row.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_res stable, req_ready=00 throughout, IDLE only after rsp_ready=1.
- Illegal op: op=4'hC, a=1, b=1 -> err=1, res=0, zf=1, cf=0, alu_op unchanged from prior op.
- Reset mid-op: assert rst_n=0 in EXEC -> immediately rsp_valid=0, alu_op=0. After release, requester 0 is granted first when both are valid.
- With ALU_ARB_FIXED_PRIO_EN: both valid for 4 ops -> all four grants to requester 0, requester 1 granted only after req_valid[0] drops.
